// File: rtl/cheri_tsmap_ctrl.sv
// CHERI temporal-safety revocation bitmap: single-cycle core lookup port plus host read/set/clear/write
// port (read-modify-write), zero-filled after reset. Build option TSMAP_PARITY_EN adds per-word even parity.
module cheri_tsmap_ctrl #(
    parameter int unsigned TSMapSize = 1024,
    parameter int unsigned CoreAddrW = 16,
    parameter int unsigned HostAddrW = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 tsmap_cs_i,
    input  logic [CoreAddrW-1:0] tsmap_addr_i,
    output logic [31:0]          tsmap_rdata_o,
    input  logic                 host_req_i,
    output logic                 host_gnt_o,
    input  logic [1:0]           host_op_i,
    input  logic [HostAddrW-1:0] host_addr_i,
    input  logic [31:0]          host_wdata_i,
    output logic                 host_rvalid_o,
    output logic [31:0]          host_rdata_o,
    output logic                 host_err_o,
    output logic                 init_done_o,
    output logic                 parity_err_o
);

    localparam int unsigned DataW = 32;
    localparam int unsigned MemAW = (TSMapSize > 1) ? $clog2(TSMapSize) : 1;
`ifdef TSMAP_PARITY_EN
    localparam int unsigned MemW  = DataW + 1;
`else
    localparam int unsigned MemW  = DataW;
`endif

    localparam logic [1:0] OpRead  = 2'b00;
    localparam logic [1:0] OpSet   = 2'b01;
    localparam logic [1:0] OpClear = 2'b10;
    localparam logic [1:0] OpWrite = 2'b11;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RD,
        ST_MOD,
        ST_WR,
        ST_RSP
    } state_e;

    state_e           state_q, state_d;
    logic [MemAW-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [MemAW-1:0] addr_q, addr_d;
    logic [DataW-1:0] wdata_q, wdata_d;
    logic [DataW-1:0] old_q, old_d;
    logic [DataW-1:0] new_q, new_d;
    logic [DataW-1:0] core_rdata_q, core_rdata_d;
    logic             err_q, err_d;
    logic             rvalid_q, rvalid_d;
    logic             init_done_q, init_done_d;

    logic [MemW-1:0]  mem_q [TSMapSize];

    logic             mem_we_c;
    logic [MemAW-1:0] mem_waddr_c;
    logic [MemAW-1:0] mem_raddr_c;
    logic [DataW-1:0] mem_wdata_c;
    logic [MemW-1:0]  mem_wword_c;
    logic [MemW-1:0]  mem_rword_c;
    logic [DataW-1:0] rd_data_c;
    logic             rd_bad_c;
    logic             core_hit_c;
    logic             host_oor_c;
    logic             host_rd_c;

    // Core owns the single array port whenever it strobes; the host only reads when it is idle.
    assign core_hit_c  = tsmap_cs_i && (state_q != ST_INIT)
                         && (32'(tsmap_addr_i) < 32'(TSMapSize));
    assign host_oor_c  = 32'(host_addr_i) >= 32'(TSMapSize);
    assign mem_raddr_c = tsmap_cs_i ? MemAW'(tsmap_addr_i) : addr_q;
    assign mem_rword_c = mem_q[mem_raddr_c];

    assign host_gnt_o  = (state_q == ST_IDLE) && host_req_i && !tsmap_cs_i;

`ifdef TSMAP_PARITY_EN
    logic perr_q;

    // Corrupted words read back as all-ones so the capability is treated as revoked.
    assign rd_bad_c    = ^mem_rword_c;
    assign rd_data_c   = rd_bad_c ? '1 : mem_rword_c[DataW-1:0];
    assign mem_wword_c = {^mem_wdata_c, mem_wdata_c};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= rd_bad_c && (core_hit_c || host_rd_c);
        end
    end

    assign parity_err_o = perr_q;
`else
    assign rd_bad_c     = 1'b0;
    assign rd_data_c    = mem_rword_c;
    assign mem_wword_c  = mem_wdata_c;
    assign parity_err_o = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        old_d       = old_q;
        new_d       = new_q;
        err_d       = err_q;
        init_done_d = init_done_q;
        host_rd_c   = 1'b0;
        mem_we_c    = 1'b0;
        mem_waddr_c = addr_q;
        mem_wdata_c = new_q;

        unique case (state_q)
            ST_INIT: begin
                if (!tsmap_cs_i) begin
                    mem_we_c    = 1'b1;
                    mem_waddr_c = cnt_q;
                    mem_wdata_c = '0;
                    cnt_d       = cnt_q + MemAW'(1);
                    if (cnt_q == MemAW'(TSMapSize - 1)) begin
                        cnt_d       = '0;
                        init_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                if (host_gnt_o) begin
                    op_d    = host_op_i;
                    addr_d  = MemAW'(host_addr_i);
                    wdata_d = host_wdata_i;
                    if (host_oor_c) begin
                        err_d   = 1'b1;
                        old_d   = '0;
                        state_d = ST_RSP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (!tsmap_cs_i) begin
                    host_rd_c = 1'b1;
                    old_d     = rd_data_c;
                    err_d     = rd_bad_c;
                    state_d   = (op_q == OpRead) ? ST_RSP : ST_MOD;
                end
            end
            ST_MOD: begin
                case (op_q)
                    OpSet:   new_d = old_q | wdata_q;
                    OpClear: new_d = old_q & ~wdata_q;
                    OpWrite: new_d = wdata_q;
                    default: new_d = old_q;
                endcase
                state_d = ST_WR;
            end
            ST_WR: begin
                // Deferred while the core strobes; the core keeps seeing the old word.
                if (!tsmap_cs_i) begin
                    mem_we_c    = 1'b1;
                    mem_waddr_c = addr_q;
                    mem_wdata_c = new_q;
                    state_d     = ST_RSP;
                end
            end
            ST_RSP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        rvalid_d     = (state_d == ST_RSP);
        core_rdata_d = tsmap_cs_i ? (core_hit_c ? rd_data_c : '0) : core_rdata_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_INIT;
            cnt_q        <= '0;
            op_q         <= OpRead;
            addr_q       <= '0;
            wdata_q      <= '0;
            old_q        <= '0;
            new_q        <= '0;
            core_rdata_q <= '0;
            err_q        <= 1'b0;
            rvalid_q     <= 1'b0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            old_q        <= old_d;
            new_q        <= new_d;
            core_rdata_q <= core_rdata_d;
            err_q        <= err_d;
            rvalid_q     <= rvalid_d;
            init_done_q  <= init_done_d;
        end
    end

    // Array contents are deliberately not reset; the INIT sweep clears them.
    always_ff @(posedge clk_i) begin
        if (mem_we_c) begin
            mem_q[mem_waddr_c] <= mem_wword_c;
        end
    end

    assign tsmap_rdata_o = core_rdata_q;
    assign host_rvalid_o = rvalid_q;
    assign host_rdata_o  = old_q;
    assign host_err_o    = err_q;
    assign init_done_o   = init_done_q;

endmodule

// File: tb/tb_cheri_tsmap_ctrl.sv
// Directed bench for cheri_tsmap_ctrl: vector table of host ops with core read-back, plus
// hand sequences for deferred writes, arbitration, reset mid-op and (TSMAP_PARITY_EN) parity faults.
module tb_cheri_tsmap_ctrl;

    localparam int unsigned TSMapSize = 1024;
    localparam int unsigned CoreAddrW = 16;
    localparam int unsigned HostAddrW = 11;

    logic                 clk;
    logic                 rst_n;
    logic                 cs;
    logic [CoreAddrW-1:0] caddr;
    logic [31:0]          crdata;
    logic                 req;
    logic                 gnt;
    logic [1:0]           op;
    logic [HostAddrW-1:0] haddr;
    logic [31:0]          hwdata;
    logic                 rvalid;
    logic [31:0]          hrdata;
    logic                 herr;
    logic                 init_done;
    logic                 perr;

    int tests = 0;
    int fails = 0;

    cheri_tsmap_ctrl #(
        .TSMapSize (TSMapSize),
        .CoreAddrW (CoreAddrW),
        .HostAddrW (HostAddrW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .tsmap_cs_i    (cs),
        .tsmap_addr_i  (caddr),
        .tsmap_rdata_o (crdata),
        .host_req_i    (req),
        .host_gnt_o    (gnt),
        .host_op_i     (op),
        .host_addr_i   (haddr),
        .host_wdata_i  (hwdata),
        .host_rvalid_o (rvalid),
        .host_rdata_o  (hrdata),
        .host_err_o    (herr),
        .init_done_o   (init_done),
        .parity_err_o  (perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]           op;
        logic [HostAddrW-1:0] haddr;
        logic [31:0]          wdata;
        logic [31:0]          exp_h;
        logic                 exp_err;
        logic [CoreAddrW-1:0] caddr;
        logic [31:0]          exp_c;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, want);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    task automatic host_op(input string name, input logic [1:0] o, input logic [HostAddrW-1:0] a,
                           input logic [31:0] d, output logic [31:0] rd, output logic e);
        int n;
        rd     = 'x;
        e      = 1'bx;
        req    = 1'b1;
        op     = o;
        haddr  = a;
        hwdata = d;
        #1;
        n = 0;
        while (!gnt && n < 50) begin
            tick();
            n++;
        end
        if (!gnt) begin
            timeout({name, "_gnt"});
            req = 1'b0;
            return;
        end
        tick();
        req = 1'b0;
        n = 0;
        while (!rvalid && n < 50) begin
            tick();
            n++;
        end
        if (!rvalid) begin
            timeout({name, "_rvalid"});
            return;
        end
        rd = hrdata;
        e  = herr;
        tick();
    endtask

    task automatic core_read(input logic [CoreAddrW-1:0] a, output logic [31:0] rd);
        cs    = 1'b1;
        caddr = a;
        tick();
        cs = 1'b0;
        rd = crdata;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (!init_done && n < 3000) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        int          n;

        rst_n  = 1'b0;
        cs     = 1'b0;
        caddr  = '0;
        req    = 1'b1;
        op     = 2'b00;
        haddr  = '0;
        hwdata = '0;

        vecs[0] = '{2'b01, 11'd5,    32'h0000_0101, 32'h0000_0000, 1'b0, 16'd5,      32'h0000_0101};
        vecs[1] = '{2'b01, 11'd5,    32'h8000_0000, 32'h0000_0101, 1'b0, 16'd5,      32'h8000_0101};
        vecs[2] = '{2'b00, 11'd5,    32'h0000_0000, 32'h8000_0101, 1'b0, 16'd5,      32'h8000_0101};
        vecs[3] = '{2'b11, 11'd9,    32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 16'd9,      32'hDEAD_BEEF};
        vecs[4] = '{2'b10, 11'd9,    32'h0000_FFFF, 32'hDEAD_BEEF, 1'b0, 16'd9,      32'hDEAD_0000};
        vecs[5] = '{2'b00, 11'd1024, 32'h0000_0000, 32'h0000_0000, 1'b1, 16'hFFFF,   32'h0000_0000};
        vecs[6] = '{2'b00, 11'd1023, 32'h0000_0000, 32'h0000_0000, 1'b0, 16'd1023,   32'h0000_0000};
        vecs[7] = '{2'b11, 11'd1023, 32'h1234_5678, 32'h0000_0000, 1'b0, 16'd1023,   32'h1234_5678};
        vecs[8] = '{2'b01, 11'd0,    32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 16'd1024,   32'h0000_0000};
        vecs[9] = '{2'b00, 11'd1023, 32'h0000_0000, 32'h1234_5678, 1'b0, 16'd0,      32'hFFFF_FFFF};

        // Reset state, with a host request pending that must not be granted.
        repeat (3) tick();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_core_rdata", crdata, 32'd0);
        check("rst_host_rdata", hrdata, 32'd0);
        check("rst_host_err", 32'(herr), 32'd0);
        check("rst_parity_err", 32'(perr), 32'd0);
        req = 1'b0;

        rst_n = 1'b1;
        wait_init(n);
        check("init_cycles", 32'(n), 32'd1024);

        core_read(16'd3, rd);
        check("post_init_core_3", rd, 32'd0);
        host_op("post_init_host", 2'b00, 11'd700, 32'd0, rd, e);
        check("post_init_host_rdata", rd, 32'd0);
        check("post_init_host_err", 32'(e), 32'd0);

        for (int i = 0; i < 10; i++) begin
            host_op($sformatf("v%0d", i), vecs[i].op, vecs[i].haddr, vecs[i].wdata, rd, e);
            check($sformatf("v%0d_host_rdata", i), rd, vecs[i].exp_h);
            check($sformatf("v%0d_host_err", i), 32'(e), 32'(vecs[i].exp_err));
            core_read(vecs[i].caddr, rd);
            check($sformatf("v%0d_core_rdata", i), rd, vecs[i].exp_c);
        end

        // Clear bit 0 of word 5 while the core holds cs through the write slot.
        req    = 1'b1;
        op     = 2'b10;
        haddr  = 11'd5;
        hwdata = 32'h0000_0001;
        #1;
        check("defer_gnt", 32'(gnt), 32'd1);
        tick();
        req = 1'b0;
        tick();
        tick();
        cs    = 1'b1;
        caddr = 16'd5;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("defer_core_%0d", k), crdata, 32'h8000_0101);
            check($sformatf("defer_norsp_%0d", k), 32'(rvalid), 32'd0);
        end
        cs = 1'b0;
        tick();
        check("defer_rvalid", 32'(rvalid), 32'd1);
        check("defer_host_rdata", hrdata, 32'h8000_0101);
        check("defer_host_err", 32'(herr), 32'd0);
        tick();
        check("defer_rvalid_pulse", 32'(rvalid), 32'd0);
        core_read(16'd5, rd);
        check("defer_core_after", rd, 32'h8000_0100);

        // Core strobe and host request collide in IDLE: core first, host granted next cycle.
        cs     = 1'b1;
        caddr  = 16'd9;
        req    = 1'b1;
        op     = 2'b00;
        haddr  = 11'd9;
        hwdata = 32'd0;
        #1;
        check("arb_gnt_blocked", 32'(gnt), 32'd0);
        tick();
        cs = 1'b0;
        #1;
        check("arb_core_rdata", crdata, 32'hDEAD_0000);
        check("arb_gnt_after", 32'(gnt), 32'd1);
        tick();
        req = 1'b0;
        n = 0;
        while (!rvalid && n < 50) begin
            tick();
            n++;
        end
        if (!rvalid) timeout("arb_rvalid");
        else check("arb_host_rdata", hrdata, 32'hDEAD_0000);
        tick();

        // Reset in the middle of a write: no response, sweep restarts, core read in INIT gives 0.
        req    = 1'b1;
        op     = 2'b11;
        haddr  = 11'd100;
        hwdata = 32'hFFFF_FFFF;
        #1;
        check("rst_mid_gnt", 32'(gnt), 32'd1);
        tick();
        req = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid_rvalid", 32'(rvalid), 32'd0);
        check("rst_mid_init_done", 32'(init_done), 32'd0);
        repeat (2) tick();
        check("rst_mid_rvalid_hold", 32'(rvalid), 32'd0);
        rst_n = 1'b1;
        core_read(16'd1023, rd);
        check("init_core_read", rd, 32'd0);
        wait_init(n);
        check("reinit_cycles", 32'(n + 1), 32'd1025);
        core_read(16'd1023, rd);
        check("reinit_core_1023", rd, 32'd0);
        host_op("reinit_host", 2'b00, 11'd100, 32'd0, rd, e);
        check("reinit_host_100", rd, 32'd0);

`ifdef TSMAP_PARITY_EN
        dut.mem_q[7] <= dut.mem_q[7] ^ 33'h1;
        #1;
        core_read(16'd7, rd);
        check("par_core_rdata", rd, 32'hFFFF_FFFF);
        check("par_err_pulse", 32'(perr), 32'd1);
        tick();
        check("par_err_clear", 32'(perr), 32'd0);
        host_op("par_host", 2'b00, 11'd7, 32'd0, rd, e);
        check("par_host_rdata", rd, 32'hFFFF_FFFF);
        check("par_host_err", 32'(e), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
